// File: rtl/pool_relu_stream.sv
// Streaming max/average pooling over 2^POOL_K_B samples per interleaved channel,
// with optional ReLU and a single-entry backpressured output register.
module pool_relu_stream #(
  parameter int unsigned DATA_WID = 16,
  parameter int unsigned CH_NUM   = 4,
  parameter int unsigned POOL_K_B = 1,
  parameter int unsigned CH_B     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       cfg_mode,
  input  logic                       cfg_relu_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_WID-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_WID-1:0] out_data,
  output logic        [CH_B-1:0]     out_ch,
  output logic                       out_last,
  output logic                       busy
);

  localparam int unsigned AccWid = DATA_WID + POOL_K_B;
  localparam logic [CH_B-1:0] ChLast = CH_B'(CH_NUM - 1);

  logic [CH_B-1:0]     ch_cnt_q, ch_cnt_d;
  logic [POOL_K_B-1:0] win_cnt_q, win_cnt_d;
  logic                mode_q, relu_q;
  logic signed [AccWid-1:0] acc_q [CH_NUM];

  logic                       out_valid_q;
  logic signed [DATA_WID-1:0] out_data_q;
  logic [CH_B-1:0]            out_ch_q;
  logic                       out_last_q;

  logic accept, take, grp_start, win_first, win_last, mode_eff, relu_eff;
  logic signed [AccWid-1:0]   samp_ext, acc_cur, acc_new, avg_sh, res_wide;
  logic signed [DATA_WID-1:0] res_raw, result;

  assign in_ready  = ~out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  // A sample accepted together with clear is dropped entirely.
  assign take      = accept & ~clear;
  assign grp_start = (ch_cnt_q == '0) && (win_cnt_q == '0);
  assign win_first = (win_cnt_q == '0);
  assign win_last  = (win_cnt_q == '1);
  // The group's first sample already uses the configuration being latched.
  assign mode_eff  = grp_start ? cfg_mode : mode_q;
  assign relu_eff  = grp_start ? cfg_relu_en : relu_q;
  assign samp_ext  = {{POOL_K_B{in_data[DATA_WID-1]}}, in_data};
  assign acc_cur   = acc_q[ch_cnt_q];

  always_comb begin
    acc_new = samp_ext;
    if (!win_first) begin
      if (mode_eff) acc_new = acc_cur + samp_ext;
      else          acc_new = (samp_ext > acc_cur) ? samp_ext : acc_cur;
    end
    avg_sh   = acc_new >>> POOL_K_B;
    res_wide = mode_eff ? avg_sh : acc_new;
    res_raw  = DATA_WID'(res_wide);
    result   = (relu_eff && res_raw[DATA_WID-1]) ? '0 : res_raw;
  end

  always_comb begin
    ch_cnt_d  = ch_cnt_q;
    win_cnt_d = win_cnt_q;
    if (clear) begin
      ch_cnt_d  = '0;
      win_cnt_d = '0;
    end else if (accept) begin
      if (ch_cnt_q == ChLast) begin
        ch_cnt_d  = '0;
        win_cnt_d = win_cnt_q + POOL_K_B'(1);
      end else begin
        ch_cnt_d = ch_cnt_q + CH_B'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_cnt_q  <= '0;
      win_cnt_q <= '0;
      mode_q    <= 1'b0;
      relu_q    <= 1'b0;
      for (int i = 0; i < int'(CH_NUM); i++) acc_q[i] <= '0;
    end else begin
      ch_cnt_q  <= ch_cnt_d;
      win_cnt_q <= win_cnt_d;
      if (take && grp_start) begin
        mode_q <= cfg_mode;
        relu_q <= cfg_relu_en;
      end
      if (take) acc_q[ch_cnt_q] <= acc_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (take && win_last) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result;
        out_ch_q    <= ch_cnt_q;
        out_last_q  <= (ch_cnt_q == ChLast);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign busy      = (ch_cnt_q != '0) || (win_cnt_q != '0);

endmodule

// File: tb/tb_pool_relu_stream.sv
// Bench for pool_relu_stream (2 channels, window 2): directed scenarios plus a
// randomized run against a per-group arithmetic reference model.
module tb_pool_relu_stream;
  localparam int DW = 16;
  localparam int CN = 2;
  localparam int KB = 1;
  localparam int K  = 1 << KB;

  logic clk = 1'b0;
  logic reset, clear, cfg_mode, cfg_relu_en, in_valid, in_ready;
  logic out_valid, out_ready, out_last, busy;
  logic signed [DW-1:0] in_data, out_data;
  logic [0:0] out_ch;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit ch;
    int d;
    bit last;
  } exp_t;

  pool_relu_stream #(.DATA_WID(DW), .CH_NUM(CN), .POOL_K_B(KB)) dut (
    .clk(clk), .reset(reset), .clear(clear), .cfg_mode(cfg_mode),
    .cfg_relu_en(cfg_relu_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW+2:0] obs();
    return {out_valid, out_ch, out_last, out_data};
  endfunction

  function automatic logic [DW+2:0] res(input bit ch, input int d, input bit last);
    logic [DW-1:0] v;
    v = DW'(d);
    return {1'b1, ch, last, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds one sample on the input until accepted (bounded).
  task automatic send(input int d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    for (int i = 0; i < 50 && !ok; i++) begin
      #4;
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL send_timeout data=%0d got in_ready=0 want accept within 50 cycles", d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; cfg_mode = 1'b0; cfg_relu_en = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    n_vec++;
    if ({in_ready, out_valid, out_data, out_ch, out_last, busy} !== {1'b1, 1'b0, 16'h0, 1'b0, 2'b00}) begin
      n_err++;
      $display("FAIL reset_values got rdy=%b v=%b d=%h ch=%b l=%b busy=%b want 1 0 0000 0 0 0",
               in_ready, out_valid, out_data, out_ch, out_last, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  // Sends four samples (one group) and checks both results back-to-back.
  task automatic run_group(input string nm, input bit mode, input bit relu,
                           input int a, input int b, input int c, input int d,
                           input int r0, input int r1);
    cfg_mode = mode; cfg_relu_en = relu; out_ready = 1'b1;
    send(a); send(b); send(c);
    n_vec++;
    if (obs() !== res(0, r0, 0)) begin
      n_err++;
      $display("FAIL %s_ch0 got %h want %h", nm, obs(), res(0, r0, 0));
    end
    send(d);
    n_vec++;
    if (obs() !== res(1, r1, 1)) begin
      n_err++;
      $display("FAIL %s_ch1 got %h want %h", nm, obs(), res(1, r1, 1));
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drain got out_valid=%b want 0", nm, out_valid);
    end
  endtask

  task automatic test_modes();
    run_group("max_relu", 1'b0, 1'b1, 5, -3, 9, -7, 9, 0);
    run_group("max_norelu", 1'b0, 1'b0, 5, -3, 9, -7, 9, -3);
    run_group("avg", 1'b1, 1'b0, 5, -3, 9, -4, 7, -4);
  endtask

  task automatic test_backpressure();
    cfg_mode = 1'b0; cfg_relu_en = 1'b0; out_ready = 1'b1;
    send(5); send(-3); send(9);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = -16'sd7;
    for (int i = 0; i < 5; i++) begin
      #4;
      n_vec++;
      if ({in_ready, obs()} !== {1'b0, res(0, 9, 0)}) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b out=%h want rdy=0 out=%h",
                 i, in_ready, obs(), res(0, 9, 0));
      end
      tick();
    end
    out_ready = 1'b1;
    #4;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release got in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (obs() !== res(1, -3, 1)) begin
      n_err++;
      $display("FAIL bp_back_to_back got %h want %h", obs(), res(1, -3, 1));
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_cfg_change();
    cfg_mode = 1'b0; cfg_relu_en = 1'b0; out_ready = 1'b1;
    send(5);
    cfg_mode = 1'b1;
    send(-3); send(9);
    n_vec++;
    if (obs() !== res(0, 9, 0)) begin
      n_err++;
      $display("FAIL cfg_hold_ch0 got %h want %h", obs(), res(0, 9, 0));
    end
    send(-4);
    n_vec++;
    if (obs() !== res(1, -3, 1)) begin
      n_err++;
      $display("FAIL cfg_hold_ch1 got %h want %h", obs(), res(1, -3, 1));
    end
    tick();
    run_group("cfg_next", 1'b1, 1'b0, 5, -3, 9, -4, 7, -4);
    cfg_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    cfg_mode = 1'b0; cfg_relu_en = 1'b0; out_ready = 1'b1;
    send(1); send(2); send(3);
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL reset_mid got busy=%b v=%b rdy=%b want 0 0 1", busy, out_valid, in_ready);
    end
    #2;
    reset = 1'b0;
    tick();
    run_group("after_reset", 1'b0, 1'b0, 1, 2, 3, 4, 3, 4);
  endtask

  task automatic test_clear_mid();
    cfg_mode = 1'b0; cfg_relu_en = 1'b0; out_ready = 1'b1;
    send(1); send(2); send(3);
    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    n_vec++;
    if ({busy, obs()} !== {1'b0, res(0, 3, 0)}) begin
      n_err++;
      $display("FAIL clear_keeps_out got busy=%b out=%h want busy=0 out=%h",
               busy, obs(), res(0, 3, 0));
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'sd100;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    n_vec++;
    if ({busy, out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL clear_discard got busy=%b v=%b want 0 0", busy, out_valid);
    end
    run_group("after_clear", 1'b0, 1'b0, 1, 2, 3, 4, 3, 4);
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int samp [CN][K];
    int mch, mw, acc, r, d;
    bit mm, mr, hs_in;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
    mch = 0; mw = 0; mm = 1'b0; mr = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      cfg_mode    = $urandom_range(0, 1);
      cfg_relu_en = $urandom_range(0, 1);
      clear       = ($urandom_range(0, 63) == 0);
      d = int'($signed(16'($urandom)));
      if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 1) ? -32768 : 32767;
      in_data = DW'(d);
      #4;
      n_vec++;
      if ({out_valid, in_ready, busy} !==
          {q.size() != 0, q.size() == 0 || out_ready, mch != 0 || mw != 0}) begin
        n_err++;
        $display("FAIL rnd_flags cyc=%0d got v=%b rdy=%b busy=%b want %b %b %b", cyc,
                 out_valid, in_ready, busy, q.size() != 0, q.size() == 0 || out_ready,
                 mch != 0 || mw != 0);
      end
      if (q.size() != 0 && out_ready) begin
        e = q.pop_front();
        n_vec++;
        if (obs() !== res(e.ch, e.d, e.last)) begin
          n_err++;
          $display("FAIL rnd_result cyc=%0d got %h want %h", cyc, obs(), res(e.ch, e.d, e.last));
        end
      end
      hs_in = in_valid && (q.size() == 0 || out_ready);
      if (clear) begin
        mch = 0; mw = 0;
      end else if (hs_in) begin
        if (mch == 0 && mw == 0) begin
          mm = cfg_mode; mr = cfg_relu_en;
        end
        samp[mch][mw] = d;
        if (mw == K - 1) begin
          acc = samp[mch][0];
          for (int w = 1; w < K; w++) begin
            if (mm) acc += samp[mch][w];
            else if (samp[mch][w] > acc) acc = samp[mch][w];
          end
          if (mm) begin
            r = acc / K;
            if (acc < 0 && acc % K != 0) r--;
          end else r = acc;
          if (mr && r < 0) r = 0;
          e.ch = mch[0]; e.d = r; e.last = (mch == CN - 1);
          q.push_back(e);
        end
        mch++;
        if (mch == CN) begin
          mch = 0;
          mw = (mw + 1) % K;
        end
      end
      tick();
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    #4;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_vec++;
      if (obs() !== res(e.ch, e.d, e.last)) begin
        n_err++;
        $display("FAIL rnd_final got %h want %h", obs(), res(e.ch, e.d, e.last));
      end
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rnd_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_cfg_change();
    test_reset_mid();
    test_clear_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pool_relu_stream.md
# pool_relu_stream

Parametrised streaming pooling + ReLU stage that sits directly after the CNN PE array output and replaces the fixed single-mode pool/ReLU stage. It accepts channel-interleaved PE results over a valid/ready stream, reduces each channel over a window of 2^POOL_K_B consecutive samples in run-time-selectable max or average mode, applies optional ReLU, and emits one result per channel per window with backpressure.

## Interface
- DATA_WID, 16: signed two's-complement sample width (in and out).
- CH_NUM, 4: interleaved channel count (≥1).
- POOL_K_B, 1: log2 of window length K (K = 2^POOL_K_B, POOL_K_B ≥ 1).
- CH_B, $clog2(CH_NUM) (min 1): channel index width.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of the group in progress.
- cfg_mode  in  1  0 = max, 1 = average.
- cfg_relu_en  in  1  1 = clamp negative results to 0.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input can be accepted.
- in_data  in  DATA_WID  signed PE result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_WID  pooled, optionally rectified result.
- out_ch  out  CH_B  channel of out_data.
- out_last  out  1  result belongs to channel CH_NUM-1 (end of group row).
- busy  out  1  a pooling group is partially accumulated.

## Operation
- Accept = in_valid & in_ready. Accepted samples belong to channels 0,1,…,CH_NUM-1,0,… in order; ch_cnt advances per accept, wraps CH_NUM-1→0; win_cnt advances on each ch_cnt wrap, wraps K-1→0.
- One group = K×CH_NUM accepts. cfg_mode and cfg_relu_en are latched on the accept starting a group (ch_cnt=0, win_cnt=0) and hold for the whole group; changes mid-group have no effect.
- Per-channel accumulator, width DATA_WID+POOL_K_B, signed.
  - win_cnt=0: accumulator loads sign-extended sample (both modes).
  - Max: acc ← max(acc, sample), signed compare.
  - Avg: acc ← acc + sample (no overflow possible by width).
- Sample with win_cnt=K-1 completes its channel: result = acc' (max) or acc' >>> POOL_K_B (arithmetic, floor toward −∞) truncated to DATA_WID; if relu latched and result negative, result = 0. Result, channel, last flag load the output register.
- in_ready = ~out_valid | out_ready, regardless of win_cnt.
- busy = 1 whenever ch_cnt≠0 or win_cnt≠0.
- clear: ch_cnt, win_cnt ← 0; sample accepted same cycle is discarded; output register untouched (pending result still delivered).

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_ch 0, out_last 0, busy 0; counters, accumulators, latched cfg all 0.
- Latency: completing sample accepted at edge N → out_valid=1 with its result after edge N (visible cycle N+1).
- out_valid holds, out_data/out_ch/out_last stable until out_valid & out_ready.
- Simultaneous out handshake and new completing accept: output register reloads same edge, out_valid stays 1 (full throughput, one result per cycle).
- out_valid=1 & out_ready=0 → in_ready=0; no sample lost or duplicated.
- Reset mid-group: all partial state discarded immediately (asynchronous); next accept is channel 0, window 0.
- CH_NUM=1: every accept is ch 0, out_last always 1 on results.

## Test plan
- Max+ReLU (CH_NUM=2, K=2): inputs 5, −3, 9, −7, out_ready=1 → outputs (ch0, 9, last 0), (ch1, 0, last 1), each one cycle after completing accept.
- Max, ReLU off, same inputs → (ch0, 9), (ch1, −3).
- Average, ReLU off: inputs 5, −3, 9, −4 → (ch0, 7), (ch1, −4) (−7>>>1 floors).
- Backpressure: out_ready=0 after first result → in_ready=0, out_data holds 9 for 5 cycles; release → ch1 result follows, no loss; back-to-back case with out_ready=1 shows out_valid continuously high.
- cfg change mid-group: cfg_mode 0→1 after first accept → group still pooled as max; next group as average.
- Reset asserted after 3 accepts, and separately clear after 3 accepts → busy 0, no output; next 4 inputs 1,2,3,4 (max) → (ch0, 3), (ch1, 4).
